// File: rtl/imem_prog_feeder.sv
// Instruction-memory program feeder: holds a small program and streams it to a
// valid/ready consumer in loop or one-shot mode, with optional periodic NOP bubbles.
module imem_prog_feeder #(
  parameter int unsigned            WORD_SIZE = 32,
  parameter int unsigned            DEPTH     = 16,
  parameter logic [WORD_SIZE-1:0]   NOP_WORD  = WORD_SIZE'(32'h00000013),
  localparam int unsigned           ADDR_W    = $clog2(DEPTH),
  localparam int unsigned           LEN_W     = ADDR_W + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_en,
  input  logic [ADDR_W-1:0]    load_addr,
  input  logic [WORD_SIZE-1:0] load_data,
  input  logic [LEN_W-1:0]     prog_len,
  input  logic [1:0]           mode,
  input  logic [3:0]           bubble_gap,
  input  logic                 start,
  input  logic                 stop,
  output logic [WORD_SIZE-1:0] instr,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [ADDR_W-1:0]    instr_idx,
  output logic                 is_bubble,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          issue_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic [ADDR_W-1:0]    idx_q, idx_d;
  logic                 bubble_q, bubble_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [3:0]           gcnt_q, gcnt_d;
  logic [3:0]           gap_q, gap_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic                 one_shot_q, one_shot_d;
  logic [ADDR_W-1:0]    pend_q, pend_d;

  logic [WORD_SIZE-1:0] mem_q [DEPTH];

  logic                 accept;
  logic                 last_entry;
  logic [ADDR_W-1:0]    next_idx;
  logic [3:0]           gcnt_inc;
  logic                 take_bubble;
  logic [LEN_W-1:0]     len_eff;

  // Program storage: written in any state, never reset; reads see the pre-edge value
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign accept      = valid_q && instr_ready;
  assign last_entry  = ({1'b0, idx_q} == (len_q - LEN_W'(1)));
  assign next_idx    = last_entry ? '0 : (idx_q + ADDR_W'(1));
  assign gcnt_inc    = gcnt_q + 4'd1;
  assign take_bubble = (gap_q != 4'd0) && (gcnt_inc == gap_q);
  assign len_eff     = ((prog_len == '0) || (prog_len > LEN_W'(DEPTH))) ? LEN_W'(DEPTH) : prog_len;

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    idx_d      = idx_q;
    bubble_d   = bubble_q;
    done_d     = done_q;
    cnt_d      = cnt_q;
    gcnt_d     = gcnt_q;
    gap_d      = gap_q;
    len_d      = len_q;
    one_shot_d = one_shot_q;
    pend_d     = pend_q;

    case (state_q)
      ST_RUN: begin
        if (stop) begin
          if (accept && !bubble_q) begin
            cnt_d = cnt_q + 32'd1;
          end
          state_d  = ST_IDLE;
          instr_d  = NOP_WORD;
          valid_d  = 1'b0;
          idx_d    = '0;
          bubble_d = 1'b0;
        end else if (accept) begin
          if (bubble_q) begin
            instr_d  = mem_q[pend_q];
            idx_d    = pend_q;
            bubble_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 32'd1;
            if (last_entry && one_shot_q) begin
              // Final one-shot entry: no trailing bubble
              state_d  = ST_DONE;
              done_d   = 1'b1;
              instr_d  = NOP_WORD;
              valid_d  = 1'b0;
              idx_d    = '0;
              bubble_d = 1'b0;
            end else if (take_bubble) begin
              instr_d  = NOP_WORD;
              idx_d    = '0;
              bubble_d = 1'b1;
              pend_d   = next_idx;
              gcnt_d   = 4'd0;
            end else begin
              instr_d  = mem_q[next_idx];
              idx_d    = next_idx;
              bubble_d = 1'b0;
              gcnt_d   = gcnt_inc;
            end
          end
        end
      end
      default: begin
        if (start && !stop) begin
          state_d    = ST_RUN;
          instr_d    = mem_q[0];
          valid_d    = 1'b1;
          idx_d      = '0;
          bubble_d   = 1'b0;
          done_d     = 1'b0;
          cnt_d      = 32'd0;
          gcnt_d     = 4'd0;
          gap_d      = bubble_gap;
          len_d      = len_eff;
          one_shot_d = (mode != 2'd0);
          pend_d     = '0;
        end else if (start && stop) begin
          state_d = ST_IDLE;
        end
      end
    endcase

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      instr_q    <= NOP_WORD;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      bubble_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= 32'd0;
      gcnt_q     <= 4'd0;
      gap_q      <= 4'd0;
      len_q      <= LEN_W'(DEPTH);
      one_shot_q <= 1'b0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      bubble_q   <= bubble_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      gcnt_q     <= gcnt_d;
      gap_q      <= gap_d;
      len_q      <= len_d;
      one_shot_q <= one_shot_d;
      pend_q     <= pend_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign instr_idx   = idx_q;
  assign is_bubble   = bubble_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign issue_cnt   = cnt_q;

endmodule

// File: tb/tb_imem_prog_feeder.sv
// Self-checking bench for imem_prog_feeder: table of program runs checked
// through an expected-beat scoreboard, plus hand-written reset/stop sequences.
module tb_imem_prog_feeder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic [4:0]  prog_len = '0;
  logic [1:0]  mode = '0;
  logic [3:0]  bubble_gap = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [3:0]  instr_idx;
  logic        is_bubble;
  logic        busy;
  logic        done;
  logic [31:0] issue_cnt;

  imem_prog_feeder dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .mode(mode),
    .bubble_gap(bubble_gap), .start(start), .stop(stop), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_idx(instr_idx),
    .is_bubble(is_bubble), .busy(busy), .done(done), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len_in;
    int mode;
    int gap;
    int rmode;    // 0 ready high, 1 pattern 1,0,0,1, 2 random
    int target;   // program words to accept
    int exp_cnt;
    bit exp_done;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    int          idx;
    bit          bub;
  } beat_t;

  int          tests = 0;
  int          failed = 0;
  logic [31:0] prog [16];
  beat_t       sb [$];
  vec_t        vecs [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      prog[i] = {7'(i), 5'(i + 2), 5'(i + 1), 3'b000, 5'(i), 7'h33};
      @(negedge clk);
      load_en = 1'b1; load_addr = 4'(i); load_data = prog[i];
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Expected beat stream for one run; loop runs get one extra beat beyond target
  task automatic plan(input vec_t t);
    int len, k, words, gcnt;
    bit one_shot, last;
    len = (t.len_in == 0 || t.len_in > 16) ? 16 : t.len_in;
    one_shot = (t.mode != 0);
    k = 0; words = 0; gcnt = 0;
    sb.delete();
    forever begin
      sb.push_back('{prog[k], k, 1'b0});
      words++; gcnt++;
      last = (k == len - 1);
      if (last && one_shot) break;
      if (words > t.target) break;
      k = last ? 0 : k + 1;
      if (t.gap != 0 && gcnt == t.gap) begin
        sb.push_back('{NOP, 0, 1'b1});
        gcnt = 0;
      end
    end
  endtask

  function automatic logic pick_ready(input int rmode, input int cyc);
    if (rmode == 0) return 1'b1;
    if (rmode == 1) return ((cyc % 4) == 0) || ((cyc % 4) == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_front(input logic r, inout int words);
    beat_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 64'(sb.size()), 64'd1);
      return;
    end
    e = sb[0];
    chk("instr", 64'(instr), 64'(e.word));
    chk("idx", 64'(instr_idx), 64'(e.idx));
    chk("bubble", 64'(is_bubble), 64'(e.bub));
    if (r) begin
      void'(sb.pop_front());
      if (!e.bub) words++;
    end
  endtask

  task automatic run_vec(input vec_t t);
    int  words, cyc;
    logic r;
    plan(t);
    @(negedge clk);
    prog_len = 5'(t.len_in); mode = 2'(t.mode); bubble_gap = 4'(t.gap);
    start = 1'b1; instr_ready = 1'b0;
    words = 0; cyc = 0;
    @(negedge clk);
    start = 1'b0;
    chk("done_clr", 64'(done), 64'd0);
    chk("busy_run", 64'(busy), 64'd1);
    forever begin
      if (!instr_valid) begin
        chk("valid_run", 64'(instr_valid), 64'd1);
        break;
      end
      r = pick_ready(t.rmode, cyc);
      instr_ready = r;
      check_front(r, words);
      if (words >= t.target) break;
      cyc++;
      if (cyc > 400) begin
        chk("timeout", 64'(words), 64'(t.target));
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (t.mode == 0) begin
      r = 1'b0;
      check_front(r, words);
      stop = 1'b1; instr_ready = 1'b0;
      @(negedge clk);
      stop = 1'b0;
    end
    instr_ready = 1'b0;
    chk("end_valid", 64'(instr_valid), 64'd0);
    chk("end_instr", 64'(instr), 64'(NOP));
    chk("end_idx", 64'(instr_idx), 64'd0);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_done", 64'(done), 64'(t.exp_done));
    chk("end_cnt", 64'(issue_cnt), 64'(t.exp_cnt));
  endtask

  initial begin
    vecs[0] = '{0,  0, 0, 0, 17, 17, 1'b0};
    vecs[1] = '{3,  1, 0, 0, 3,  3,  1'b1};
    vecs[2] = '{4,  1, 2, 0, 4,  4,  1'b1};
    vecs[3] = '{5,  0, 0, 1, 8,  8,  1'b0};
    vecs[4] = '{20, 1, 3, 2, 16, 16, 1'b1};
    vecs[5] = '{6,  0, 4, 0, 14, 14, 1'b0};
    vecs[6] = '{1,  1, 0, 1, 1,  1,  1'b1};
    vecs[7] = '{2,  2, 1, 0, 2,  2,  1'b1};

    // Asynchronous reset, observed before any clock edge
    #2 reset = 1'b1;
    #1;
    chk("rst_instr", 64'(instr), 64'(NOP));
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cnt", 64'(issue_cnt), 64'd0);
    chk("rst_idx", 64'(instr_idx), 64'd0);
    chk("rst_bub", 64'(is_bubble), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    load_prog();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset mid-RUN at idx 5, then restart on the first edge after release
    @(negedge clk);
    prog_len = 5'd0; mode = 2'd0; bubble_gap = 4'd0; start = 1'b1; instr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 40 && instr_idx != 4'd5; c++) @(negedge clk);
    chk("reach_idx5", 64'(instr_idx), 64'd5);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(instr_valid), 64'd0);
    chk("mid_rst_instr", 64'(instr), 64'(NOP));
    chk("mid_rst_cnt", 64'(issue_cnt), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0; start = 1'b1; instr_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("rs_instr0", 64'(instr), 64'(prog[0]));
    chk("rs_valid", 64'(instr_valid), 64'd1);
    instr_ready = 1'b1;
    @(negedge clk);
    chk("rs_instr1", 64'(instr), 64'(prog[1]));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ignored_idx", 64'(instr_idx), 64'd2);
    chk("start_ignored_cnt", 64'(issue_cnt), 64'd2);

    // Stop with ready high: the final beat is counted
    stop = 1'b1; instr_ready = 1'b1;
    @(negedge clk);
    stop = 1'b0; instr_ready = 1'b0;
    chk("stop_cnt", 64'(issue_cnt), 64'd3);
    chk("stop_valid", 64'(instr_valid), 64'd0);
    chk("stop_busy", 64'(busy), 64'd0);
    chk("stop_instr", 64'(instr), 64'(NOP));

    // Start and stop together in IDLE: stop wins
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", 64'(busy), 64'd0);
    chk("ss_valid", 64'(instr_valid), 64'd0);
    @(negedge clk);
    chk("ss_hold_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
